// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: captures one record per retired instruction, filters
// repeated-pc retirements, buffers records in a FIFO drained by valid/ready,
// and stops capturing once a programmable record limit is reached.
module commit_trace_fifo #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned MAX_RECORDS = 5000,
   parameter bit          DEDUP       = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cm_valid,
   input  logic [31:0]              cm_pc,
   input  logic [31:0]              cm_inst,
   input  logic                     cm_we,
   input  logic [4:0]               cm_waddr,
   input  logic [31:0]              cm_wdata,
   output logic                     tr_valid,
   input  logic                     tr_ready,
   output logic [31:0]              tr_pc,
   output logic [31:0]              tr_inst,
   output logic                     tr_we,
   output logic [4:0]               tr_waddr,
   output logic [31:0]              tr_wdata,
   output logic [15:0]              tr_seq,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [15:0]              drop_cnt,
   output logic                     done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [15:0] seq;
   } rec_t;

   rec_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   fill_q, fill_d;
   logic [15:0]   seq_q, seq_d;
   logic [31:0]   last_pc_q, last_pc_d;
   logic          last_pc_vld_q, last_pc_vld_d;
   logic [31:0]   acc_cnt_q, acc_cnt_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          done_q, done_d;

   logic full, pop, dup, accept, push, lost;
   rec_t new_rec, head;

   // Handshake and acceptance decode; cm_valid gates every data-dependent term
   always_comb begin
      full   = (fill_q == FULL_LVL);
      pop    = (fill_q != '0) && tr_ready;
      dup    = DEDUP && last_pc_vld_q && (cm_pc == last_pc_q);
      accept = cm_valid && !done_q && !dup;
      push   = accept && (!full || pop);
      lost   = accept && full && !pop;

      new_rec       = '0;
      new_rec.pc    = cm_pc;
      new_rec.inst  = cm_inst;
      new_rec.we    = cm_we;
      new_rec.waddr = cm_we ? cm_waddr : '0;
      new_rec.wdata = cm_we ? cm_wdata : '0;
      new_rec.seq   = seq_q;
   end

   // Next-state computation for pointers, counters and capture status
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      fill_d        = fill_q;
      seq_d         = seq_q;
      last_pc_d     = last_pc_q;
      last_pc_vld_d = last_pc_vld_q;
      acc_cnt_d     = acc_cnt_q;
      drop_cnt_d    = drop_cnt_q;
      done_d        = done_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase

      if (accept) begin
         last_pc_d     = cm_pc;
         last_pc_vld_d = 1'b1;
         seq_d         = seq_q + 1'b1;
         acc_cnt_d     = acc_cnt_q + 1'b1;
         if ((MAX_RECORDS != 0) && (acc_cnt_d == 32'(MAX_RECORDS)))
            done_d = 1'b1;
      end

      if (lost && (drop_cnt_q != '1))
         drop_cnt_d = drop_cnt_q + 1'b1;
   end

   // Control state registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fill_q        <= '0;
         seq_q         <= '0;
         last_pc_q     <= '0;
         last_pc_vld_q <= 1'b0;
         acc_cnt_q     <= '0;
         drop_cnt_q    <= '0;
         done_q        <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fill_q        <= fill_d;
         seq_q         <= seq_d;
         last_pc_q     <= last_pc_d;
         last_pc_vld_q <= last_pc_vld_d;
         acc_cnt_q     <= acc_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         done_q        <= done_d;
      end
   end

   // Record storage; contents need no reset because fill gates visibility
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= new_rec;
   end

   // Head record outputs, forced to zero while empty so reset clears them at once
   always_comb begin
      head     = mem_q[rd_ptr_q];
      tr_valid = (fill_q != '0);
      tr_pc    = tr_valid ? head.pc    : '0;
      tr_inst  = tr_valid ? head.inst  : '0;
      tr_we    = tr_valid ? head.we    : 1'b0;
      tr_waddr = tr_valid ? head.waddr : '0;
      tr_wdata = tr_valid ? head.wdata : '0;
      tr_seq   = tr_valid ? head.seq   : '0;
      fill     = fill_q;
      drop_cnt = drop_cnt_q;
      done     = done_q;
   end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo: three instances (dedup on, dedup off,
// record limit 3) share the retirement stimulus, each with its own reset.
module tb_commit_trace_fifo;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, rst_c;
   logic        cm_valid;
   logic [31:0] cm_pc, cm_inst, cm_wdata;
   logic        cm_we;
   logic [4:0]  cm_waddr;
   logic        tr_ready;

   logic        a_valid, a_we, a_done;
   logic [31:0] a_pc, a_inst, a_wdata;
   logic [4:0]  a_waddr;
   logic [15:0] a_seq, a_drop;
   logic [2:0]  a_fill;

   logic        b_valid, b_we, b_done;
   logic [31:0] b_pc, b_inst, b_wdata;
   logic [4:0]  b_waddr;
   logic [15:0] b_seq, b_drop;
   logic [2:0]  b_fill;

   logic        c_valid, c_we, c_done;
   logic [31:0] c_pc, c_inst, c_wdata;
   logic [4:0]  c_waddr;
   logic [15:0] c_seq, c_drop;
   logic [2:0]  c_fill;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   commit_trace_fifo #(.DEPTH(4), .MAX_RECORDS(5000), .DEDUP(1'b1)) u_a (
      .clk(clk), .rst(rst_a), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
      .cm_we(cm_we), .cm_waddr(cm_waddr), .cm_wdata(cm_wdata),
      .tr_valid(a_valid), .tr_ready(tr_ready), .tr_pc(a_pc), .tr_inst(a_inst),
      .tr_we(a_we), .tr_waddr(a_waddr), .tr_wdata(a_wdata), .tr_seq(a_seq),
      .fill(a_fill), .drop_cnt(a_drop), .done(a_done));

   commit_trace_fifo #(.DEPTH(4), .MAX_RECORDS(5000), .DEDUP(1'b0)) u_b (
      .clk(clk), .rst(rst_b), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
      .cm_we(cm_we), .cm_waddr(cm_waddr), .cm_wdata(cm_wdata),
      .tr_valid(b_valid), .tr_ready(tr_ready), .tr_pc(b_pc), .tr_inst(b_inst),
      .tr_we(b_we), .tr_waddr(b_waddr), .tr_wdata(b_wdata), .tr_seq(b_seq),
      .fill(b_fill), .drop_cnt(b_drop), .done(b_done));

   commit_trace_fifo #(.DEPTH(4), .MAX_RECORDS(3), .DEDUP(1'b1)) u_c (
      .clk(clk), .rst(rst_c), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
      .cm_we(cm_we), .cm_waddr(cm_waddr), .cm_wdata(cm_wdata),
      .tr_valid(c_valid), .tr_ready(tr_ready), .tr_pc(c_pc), .tr_inst(c_inst),
      .tr_we(c_we), .tr_waddr(c_waddr), .tr_wdata(c_wdata), .tr_seq(c_seq),
      .fill(c_fill), .drop_cnt(c_drop), .done(c_done));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [31:0] pc,
                        input logic [15:0] seq, input logic [2:0] f);
      chk({tag, ".a_valid"}, 32'(a_valid), 32'(v));
      chk({tag, ".a_pc"},    a_pc,         pc);
      chk({tag, ".a_seq"},   32'(a_seq),   32'(seq));
      chk({tag, ".a_fill"},  32'(a_fill),  32'(f));
   endtask

   task automatic chk_b(input string tag, input logic v, input logic [31:0] pc,
                        input logic [15:0] seq, input logic [2:0] f);
      chk({tag, ".b_valid"}, 32'(b_valid), 32'(v));
      chk({tag, ".b_pc"},    b_pc,         pc);
      chk({tag, ".b_seq"},   32'(b_seq),   32'(seq));
      chk({tag, ".b_fill"},  32'(b_fill),  32'(f));
   endtask

   task automatic chk_c(input string tag, input logic v, input logic [31:0] pc,
                        input logic [15:0] seq, input logic [2:0] f, input logic d);
      chk({tag, ".c_valid"}, 32'(c_valid), 32'(v));
      chk({tag, ".c_pc"},    c_pc,         pc);
      chk({tag, ".c_seq"},   32'(c_seq),   32'(seq));
      chk({tag, ".c_fill"},  32'(c_fill),  32'(f));
      chk({tag, ".c_done"},  32'(c_done),  32'(d));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                         input logic [4:0] waddr, input logic [31:0] wdata);
      cm_valid = 1'b1;
      cm_pc    = pc;
      cm_inst  = inst;
      cm_we    = we;
      cm_waddr = waddr;
      cm_wdata = wdata;
   endtask

   task automatic idle;
      cm_valid = 1'b0;
      cm_pc    = 'x;
      cm_inst  = 'x;
      cm_we    = 1'bx;
      cm_waddr = 'x;
      cm_wdata = 'x;
   endtask

   task automatic pulse_rst_a;
      rst_a = 1'b0;
      #1;
      rst_a = 1'b1;
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      tr_ready = 1'b0;
      idle();
      #1;
      // reset state
      chk_a("rst", 1'b0, 32'h0, 16'd0, 3'd0);
      chk("rst.a_drop", 32'(a_drop), 32'd0);
      chk("rst.a_done", 32'(a_done), 32'd0);
      chk("rst.a_waddr", 32'(a_waddr), 32'd0);
      chk("rst.a_wdata", a_wdata, 32'h0);
      tick(); tick();
      rst_a = 1'b1;

      // basic capture, 1-cycle latency, drain in step
      tr_ready = 1'b1;
      retire(32'h00400000, 32'h00000013, 1'b1, 5'd5, 32'h11);
      tick();
      chk_a("cap0", 1'b1, 32'h00400000, 16'd0, 3'd1);
      chk("cap0.inst",  a_inst, 32'h00000013);
      chk("cap0.waddr", 32'(a_waddr), 32'd5);
      chk("cap0.wdata", a_wdata, 32'h11);
      retire(32'h00400004, 32'h00100093, 1'b0, 5'd7, 32'hdead);
      tick();
      chk_a("cap1", 1'b1, 32'h00400004, 16'd1, 3'd1);
      chk("cap1.we",    32'(a_we), 32'd0);
      chk("cap1.waddr", 32'(a_waddr), 32'd0);
      chk("cap1.wdata", a_wdata, 32'h0);
      retire(32'h00400008, 32'h00200113, 1'b1, 5'd31, 32'hcafef00d);
      tick();
      chk_a("cap2", 1'b1, 32'h00400008, 16'd2, 3'd1);
      chk("cap2.waddr", 32'(a_waddr), 32'd31);
      chk("cap2.wdata", a_wdata, 32'hcafef00d);
      idle();
      tick();
      chk_a("cap_empty", 1'b0, 32'h0, 16'd0, 3'd0);

      // dedup enabled
      pulse_rst_a();
      retire(32'h00400010, 32'h1, 1'b1, 5'd1, 32'h1);
      tick();
      chk_a("dd0", 1'b1, 32'h00400010, 16'd0, 3'd1);
      tick();
      chk_a("dd_dup", 1'b0, 32'h0, 16'd0, 3'd0);
      retire(32'h00400014, 32'h2, 1'b1, 5'd2, 32'h2);
      tick();
      chk_a("dd1", 1'b1, 32'h00400014, 16'd1, 3'd1);
      idle();
      tick();
      chk_a("dd_empty", 1'b0, 32'h0, 16'd0, 3'd0);

      // dedup disabled
      rst_a = 1'b0;
      rst_b = 1'b1;
      retire(32'h00400010, 32'h1, 1'b1, 5'd1, 32'h1);
      tick();
      chk_b("nd0", 1'b1, 32'h00400010, 16'd0, 3'd1);
      tick();
      chk_b("nd1", 1'b1, 32'h00400010, 16'd1, 3'd1);
      retire(32'h00400014, 32'h2, 1'b1, 5'd2, 32'h2);
      tick();
      chk_b("nd2", 1'b1, 32'h00400014, 16'd2, 3'd1);
      idle();
      tick();
      chk_b("nd_empty", 1'b0, 32'h0, 16'd0, 3'd0);
      chk("nd.drop", 32'(b_drop), 32'd0);
      rst_b = 1'b0;

      // overflow with consumer stalled
      rst_a = 1'b1;
      tr_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         retire(32'h100 + 32'(4 * i), 32'h40 + 32'(i), 1'b1, 5'(i + 1), 32'(i));
         tick();
         chk("ovf.fill", 32'(a_fill), (i < 4) ? 32'(i + 1) : 32'd4);
      end
      idle();
      tick(); tick();
      chk_a("ovf_hold", 1'b1, 32'h100, 16'd0, 3'd4);
      chk("ovf.drop", 32'(a_drop), 32'd2);
      tr_ready = 1'b1;
      tick();
      chk_a("drn1", 1'b1, 32'h104, 16'd1, 3'd3);
      tick();
      chk_a("drn2", 1'b1, 32'h108, 16'd2, 3'd2);
      tick();
      chk_a("drn3", 1'b1, 32'h10c, 16'd3, 3'd1);
      chk("drn3.wdata", a_wdata, 32'd3);
      tick();
      chk_a("drn_empty", 1'b0, 32'h0, 16'd0, 3'd0);

      // push and pop together while full; seq continues from 6
      tr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         retire(32'h300 + 32'(4 * i), 32'h0, 1'b1, 5'd9, 32'h300 + 32'(i));
         tick();
      end
      chk_a("fp_full", 1'b1, 32'h300, 16'd6, 3'd4);
      tr_ready = 1'b1;
      retire(32'h310, 32'h0, 1'b1, 5'd9, 32'h310);
      tick();
      chk_a("fp_pp", 1'b1, 32'h304, 16'd7, 3'd4);
      chk("fp_pp.drop", 32'(a_drop), 32'd2);
      idle();
      tick();
      chk_a("fp_d8", 1'b1, 32'h308, 16'd8, 3'd3);
      tick();
      chk_a("fp_d9", 1'b1, 32'h30c, 16'd9, 3'd2);
      tick();
      chk_a("fp_d10", 1'b1, 32'h310, 16'd10, 3'd1);
      chk("fp_d10.wdata", a_wdata, 32'h310);
      tick();
      chk_a("fp_empty", 1'b0, 32'h0, 16'd0, 3'd0);

      // asynchronous reset mid-cycle
      tr_ready = 1'b0;
      retire(32'h400, 32'h0, 1'b1, 5'd3, 32'h4);
      tick();
      retire(32'h404, 32'h0, 1'b1, 5'd3, 32'h5);
      tick();
      chk_a("ar_pre", 1'b1, 32'h400, 16'd11, 3'd2);
      idle();
      #3;
      rst_a = 1'b0;
      #1;
      chk_a("ar_now", 1'b0, 32'h0, 16'd0, 3'd0);
      chk("ar_now.done", 32'(a_done), 32'd0);
      chk("ar_now.drop", 32'(a_drop), 32'd0);
      rst_a = 1'b1;
      retire(32'h500, 32'h0, 1'b1, 5'd3, 32'h6);
      tick();
      chk_a("ar_post", 1'b1, 32'h500, 16'd0, 3'd1);
      idle();
      rst_a = 1'b0;

      // record limit of 3
      rst_c = 1'b1;
      tr_ready = 1'b0;
      retire(32'h600, 32'h0, 1'b1, 5'd1, 32'h1);
      tick();
      chk_c("lim1", 1'b1, 32'h600, 16'd0, 3'd1, 1'b0);
      retire(32'h604, 32'h0, 1'b1, 5'd1, 32'h2);
      tick();
      chk_c("lim2", 1'b1, 32'h600, 16'd0, 3'd2, 1'b0);
      retire(32'h608, 32'h0, 1'b1, 5'd1, 32'h3);
      tick();
      chk_c("lim3", 1'b1, 32'h600, 16'd0, 3'd3, 1'b1);
      retire(32'h60c, 32'h0, 1'b1, 5'd1, 32'h4);
      tick();
      retire(32'h610, 32'h0, 1'b1, 5'd1, 32'h5);
      tick();
      chk_c("lim5", 1'b1, 32'h600, 16'd0, 3'd3, 1'b1);
      chk("lim5.drop", 32'(c_drop), 32'd0);
      idle();
      tr_ready = 1'b1;
      tick();
      chk_c("limd1", 1'b1, 32'h604, 16'd1, 3'd2, 1'b1);
      tick();
      chk_c("limd2", 1'b1, 32'h608, 16'd2, 3'd1, 1'b1);
      tick();
      chk_c("limd_empty", 1'b0, 32'h0, 16'd0, 3'd0, 1'b1);
      retire(32'h700, 32'h0, 1'b1, 5'd1, 32'h7);
      tick();
      chk_c("lim_stuck", 1'b0, 32'h0, 16'd0, 3'd0, 1'b1);
      idle();
      rst_c = 1'b0;
      #1;
      chk("lim_rst.done", 32'(c_done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
